// File: rtl/conv1_frame_ctrl_if.sv
// Memory read bus and window-buffer stream seen by conv1_frame_ctrl.
// master = frame controller, slave = memory / window buffer side.
interface conv1_frame_ctrl_if #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 10
);
  logic                 mem_rd_en;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0] mem_rd_data;
  logic [DATA_BITS-1:0] pix_out;
  logic                 pix_valid;
  logic                 win_valid;
  logic [4:0]           win_row;
  logic [4:0]           win_col;

  modport master (
    output mem_rd_en, mem_addr, pix_out, pix_valid, win_row, win_col,
    input  mem_rd_data, win_valid
  );

  modport slave (
    input  mem_rd_en, mem_addr, pix_out, pix_valid, win_row, win_col,
    output mem_rd_data, win_valid
  );
endinterface

// File: rtl/conv1_frame_ctrl.sv
// Frame sequencer for the conv1 5x5 window buffer: raster-reads one frame from
// image memory, streams it as pixels, and tracks the windows the buffer flags.
module conv1_frame_ctrl #(
  parameter int WIDTH       = 28,
  parameter int HEIGHT      = 28,
  parameter int FILTER_SIZE = 5,
  parameter int DATA_BITS   = 8,
  parameter int ADDR_BITS   = 10,
  parameter int DRAIN_TO    = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_BITS-1:0] img_base,
  input  logic                 hold,
  conv1_frame_ctrl_if.master   bus,
  output logic [9:0]           win_count,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout
);
  localparam int NPIX      = WIDTH * HEIGHT;
  localparam int COL_MAX   = WIDTH - FILTER_SIZE;
  localparam int ROW_MAX   = HEIGHT - FILTER_SIZE;
  localparam int NWIN      = (COL_MAX + 1) * (ROW_MAX + 1);
  localparam int PIX_BITS  = $clog2(NPIX + 1);
  localparam int IDLE_BITS = $clog2(DRAIN_TO);

  localparam logic [PIX_BITS-1:0]  PIX_LAST  = PIX_BITS'(NPIX - 1);
  localparam logic [9:0]           NWIN_C    = 10'(NWIN);
  localparam logic [4:0]           COL_MAX_C = 5'(COL_MAX);
  localparam logic [4:0]           ROW_MAX_C = 5'(ROW_MAX);
  localparam logic [IDLE_BITS-1:0] IDLE_LAST = IDLE_BITS'(DRAIN_TO - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state_r;
  logic [ADDR_BITS-1:0]   base_r;
  logic [PIX_BITS-1:0]    pix_idx_r;
  logic [IDLE_BITS-1:0]   idle_cnt_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   err_r;
  logic                   rd_pend_r;
  logic                   pix_valid_r;
  logic [DATA_BITS-1:0]   pix_out_r;
  logic [9:0]             win_count_r;
  logic [4:0]             win_row_r;
  logic [4:0]             win_col_r;
  logic [4:0]             nxt_row_r;
  logic [4:0]             nxt_col_r;

  logic                   rd_fire_s;
  logic                   start_acc_s;
  logic                   win_take_s;

  // The read strobe follows hold in the same cycle so a held cycle issues nothing.
  assign rd_fire_s   = (state_r == S_READ) & ~hold;
  assign start_acc_s = (state_r == S_IDLE) & start & ~abort;
  assign win_take_s  = busy_r & bus.win_valid & ~abort & (win_count_r < NWIN_C);

  assign bus.mem_rd_en = rd_fire_s;
  assign bus.mem_addr  = base_r + ADDR_BITS'(pix_idx_r);
  assign bus.pix_out   = pix_out_r;
  assign bus.pix_valid = pix_valid_r;
  assign bus.win_row   = win_row_r;
  assign bus.win_col   = win_col_r;
  assign win_count     = win_count_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign err_timeout   = err_r;

  // Frame sequencing: state, read index, drain watchdog and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      base_r     <= '0;
      pix_idx_r  <= '0;
      idle_cnt_r <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else if (abort) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            base_r    <= img_base;
            pix_idx_r <= '0;
            err_r     <= 1'b0;
            busy_r    <= 1'b1;
            state_r   <= S_READ;
          end
        end
        S_READ: begin
          if (rd_fire_s) begin
            if (pix_idx_r == PIX_LAST) begin
              idle_cnt_r <= '0;
              state_r    <= S_DRAIN;
            end else begin
              pix_idx_r <= pix_idx_r + PIX_BITS'(1);
            end
          end
        end
        S_DRAIN: begin
          if (win_count_r == NWIN_C) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= S_DONE;
          end else if (bus.win_valid) begin
            idle_cnt_r <= '0;
          end else if (idle_cnt_r == IDLE_LAST) begin
            err_r   <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= S_DONE;
          end else begin
            idle_cnt_r <= idle_cnt_r + IDLE_BITS'(1);
          end
        end
        S_DONE: begin
          done_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Two-stage pixel pipe matching the one-cycle memory read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_r   <= 1'b0;
      pix_valid_r <= 1'b0;
      pix_out_r   <= '0;
    end else begin
      rd_pend_r   <= rd_fire_s & ~abort;
      pix_valid_r <= rd_pend_r & ~abort;
      if (rd_pend_r) begin
        pix_out_r <= bus.mem_rd_data;
      end
    end
  end

  // Window bookkeeping: count flagged windows and report where the latest one sits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_count_r <= '0;
      win_row_r   <= '0;
      win_col_r   <= '0;
      nxt_row_r   <= '0;
      nxt_col_r   <= '0;
    end else if (start_acc_s) begin
      win_count_r <= '0;
      win_row_r   <= '0;
      win_col_r   <= '0;
      nxt_row_r   <= '0;
      nxt_col_r   <= '0;
    end else if (win_take_s) begin
      win_count_r <= win_count_r + 10'd1;
      win_row_r   <= nxt_row_r;
      win_col_r   <= nxt_col_r;
      if (nxt_col_r == COL_MAX_C) begin
        nxt_col_r <= 5'd0;
        if (nxt_row_r != ROW_MAX_C) begin
          nxt_row_r <= nxt_row_r + 5'd1;
        end
      end else begin
        nxt_col_r <= nxt_col_r + 5'd1;
      end
    end
  end
endmodule

// File: tb/tb_conv1_frame_ctrl.sv
// Directed bench for conv1_frame_ctrl with a memory model and a window-buffer stub.
module tb_conv1_frame_ctrl;
  localparam int NPIX = 784;
  localparam int NWIN = 576;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, hold;
  logic [9:0] img_base;
  logic [9:0] win_count;
  logic       busy, done, err_timeout;

  conv1_frame_ctrl_if #(.DATA_BITS(8), .ADDR_BITS(10)) bus();

  conv1_frame_ctrl #(
    .WIDTH(28), .HEIGHT(28), .FILTER_SIZE(5), .DATA_BITS(8), .ADDR_BITS(10), .DRAIN_TO(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .img_base(img_base),
    .hold(hold), .bus(bus), .win_count(win_count), .busy(busy), .done(done),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [9:0] addr_log [0:1023];
  int         rd_cyc_log [0:1023];
  logic [7:0] pix_log [0:1023];
  int         pix_cyc_log [0:1023];
  logic [4:0] wrow_log [0:1023];
  logic [4:0] wcol_log [0:1023];
  int n_reads, n_pix, n_win, done_cnt, done_cyc;
  logic busy_at_done, err_at_done;
  logic [9:0] wc_at_done;
  int win_mode, win_limit, win_sent;

  logic prev_rd, prev_pv, prev_wv;
  logic [9:0] prev_addr;
  int prev_pv_idx;

  logic rd_en_s, pv_s, busy_s, done_s, err_s;
  logic [9:0] addr_s, wc_s;
  logic [7:0] pix_s;
  logic [4:0] wr_s, wcl_s;

  function automatic logic [7:0] mem_val(input logic [9:0] a);
    return a[7:0] ^ {6'd0, a[9:8]} ^ 8'h3C;
  endfunction

  task automatic clear_log();
    n_reads = 0; n_pix = 0; n_win = 0; done_cnt = 0; done_cyc = 0;
    win_sent = 0; prev_pv = 1'b0; prev_wv = 1'b0;
  endtask

  task automatic sample();
    rd_en_s = bus.mem_rd_en; addr_s = bus.mem_addr; pv_s = bus.pix_valid; pix_s = bus.pix_out;
    wr_s = bus.win_row; wcl_s = bus.win_col; wc_s = win_count;
    busy_s = busy; done_s = done; err_s = err_timeout;
  endtask

  // One clock cycle: drive at the falling edge, then sample 1 time unit later.
  task automatic cycle(input logic st, input logic ab, input logic hd);
    @(negedge clk);
    start = st; abort = ab; hold = hd;
    bus.mem_rd_data = prev_rd ? mem_val(prev_addr) : 8'h00;
    bus.win_valid = 1'b0;
    if (win_sent < win_limit) begin
      if (win_mode == 1 && prev_pv && (prev_pv_idx / 28) >= 4 && (prev_pv_idx % 28) >= 4)
        bus.win_valid = 1'b1;
      if (win_mode == 2 && n_reads == NPIX)
        bus.win_valid = 1'b1;
    end
    if (bus.win_valid) win_sent++;
    #1;
    sample();
    if (prev_wv && n_win < 1024) begin
      wrow_log[n_win] = wr_s; wcol_log[n_win] = wcl_s; n_win++;
    end
    prev_wv = bus.win_valid;
    prev_rd = rd_en_s; prev_addr = addr_s;
    if (rd_en_s && n_reads < 1024) begin
      addr_log[n_reads] = addr_s; rd_cyc_log[n_reads] = cyc; n_reads++;
    end
    prev_pv = pv_s; prev_pv_idx = n_pix;
    if (pv_s && n_pix < 1024) begin
      pix_log[n_pix] = pix_s; pix_cyc_log[n_pix] = cyc; n_pix++;
    end
    if (done_s) begin
      done_cnt++; done_cyc = cyc; busy_at_done = busy_s; wc_at_done = wc_s; err_at_done = err_s;
    end
    cyc++;
  endtask

  task automatic run_to_done(input int max_cyc);
    for (int i = 0; i < max_cyc && done_cnt == 0; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0; img_base = 10'd0;
    bus.mem_rd_data = 8'h00; bus.win_valid = 1'b0;
    prev_rd = 1'b0; prev_addr = 10'd0; win_mode = 0; win_limit = 0;
    clear_log();
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if ({rd_en_s, addr_s, pv_s, pix_s} !== 20'd0) begin
      errors++; $display("FAIL reset_bus: got %h expected 0", {rd_en_s, addr_s, pv_s, pix_s});
    end
    checks++;
    if ({busy_s, done_s, err_s, wc_s, wr_s, wcl_s} !== 23'd0) begin
      errors++; $display("FAIL reset_status: got %h expected 0", {busy_s, done_s, err_s, wc_s, wr_s, wcl_s});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_stream();
    int start_cyc, bad;
    clear_log(); win_mode = 1; win_limit = 1000; img_base = 10'd0;
    start_cyc = cyc;
    cycle(1'b1, 1'b0, 1'b0);
    run_to_done(1500);
    checks++;
    if (n_reads !== NPIX) begin errors++; $display("FAIL stream_reads: got %0d expected %0d", n_reads, NPIX); end
    checks++;
    if (rd_cyc_log[0] !== start_cyc + 1) begin
      errors++; $display("FAIL stream_first_read: got cycle %0d expected %0d", rd_cyc_log[0], start_cyc + 1);
    end
    checks++;
    if (rd_cyc_log[NPIX-1] - rd_cyc_log[0] !== NPIX - 1) begin
      errors++; $display("FAIL stream_contiguous: got span %0d expected %0d", rd_cyc_log[NPIX-1] - rd_cyc_log[0], NPIX - 1);
    end
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (addr_log[i] !== 10'(i)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL stream_addr: got %0d bad addresses expected 0", bad); end
    checks++;
    if (pix_cyc_log[0] !== rd_cyc_log[0] + 2) begin
      errors++; $display("FAIL stream_latency: got %0d expected 2", pix_cyc_log[0] - rd_cyc_log[0]);
    end
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (pix_log[i] !== mem_val(addr_log[i])) bad++;
    checks++;
    if (n_pix !== NPIX || bad !== 0) begin
      errors++; $display("FAIL stream_pixels: got %0d beats %0d bad expected %0d beats 0 bad", n_pix, bad, NPIX);
    end
    checks++;
    if (done_cnt !== 1 || busy_at_done !== 1'b0) begin
      errors++; $display("FAIL stream_done: got done_cnt %0d busy %b expected 1 and 0", done_cnt, busy_at_done);
    end
    checks++;
    if (wc_at_done !== 10'd576 || err_at_done !== 1'b0) begin
      errors++; $display("FAIL stream_count: got %0d err %b expected 576 err 0", wc_at_done, err_at_done);
    end
    cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (done_s !== 1'b0) begin errors++; $display("FAIL stream_done_pulse: got done %b expected 0", done_s); end
  endtask

  task automatic test_window_track();
    int bad;
    clear_log(); win_mode = 1; win_limit = 1000; img_base = 10'd200;
    cycle(1'b1, 1'b0, 1'b0);
    run_to_done(1500);
    checks++;
    if (n_win !== NWIN) begin errors++; $display("FAIL win_flags: got %0d expected %0d", n_win, NWIN); end
    checks++;
    if ({wrow_log[23], wcol_log[23], wrow_log[24], wcol_log[24]} !== {5'd0, 5'd23, 5'd1, 5'd0}) begin
      errors++; $display("FAIL win_wrap: got r%0d c%0d then r%0d c%0d expected r0 c23 then r1 c0",
                         wrow_log[23], wcol_log[23], wrow_log[24], wcol_log[24]);
    end
    checks++;
    if ({wrow_log[575], wcol_log[575]} !== {5'd23, 5'd23}) begin
      errors++; $display("FAIL win_last: got r%0d c%0d expected r23 c23", wrow_log[575], wcol_log[575]);
    end
    bad = 0;
    for (int k = 0; k < NWIN; k++) if (wrow_log[k] !== 5'(k / 24) || wcol_log[k] !== 5'(k % 24)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL win_positions: got %0d bad expected 0", bad); end
  endtask

  task automatic test_hold();
    int pix_before, rd_during, bad;
    clear_log(); win_mode = 1; win_limit = 1000; img_base = 10'd50;
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 200 && n_reads < 100; i++) cycle(1'b0, 1'b0, 1'b0);
    pix_before = n_pix; rd_during = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      if (rd_en_s) rd_during++;
    end
    checks++;
    if (rd_during !== 0) begin errors++; $display("FAIL hold_rd_en: got %0d reads expected 0", rd_during); end
    checks++;
    if (n_pix - pix_before !== 2) begin
      errors++; $display("FAIL hold_inflight: got %0d beats expected 2", n_pix - pix_before);
    end
    run_to_done(1500);
    checks++;
    if (addr_log[100] !== 10'd150 || rd_cyc_log[100] - rd_cyc_log[99] !== 4) begin
      errors++; $display("FAIL hold_resume: got addr %0d gap %0d expected 150 gap 4", addr_log[100], rd_cyc_log[100] - rd_cyc_log[99]);
    end
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (pix_log[i] !== mem_val(addr_log[i])) bad++;
    checks++;
    if (n_reads !== NPIX || n_pix !== NPIX || bad !== 0) begin
      errors++; $display("FAIL hold_total: got %0d reads %0d beats %0d bad expected 784 784 0", n_reads, n_pix, bad);
    end
    checks++;
    if (done_cnt !== 1 || wc_at_done !== 10'd576) begin
      errors++; $display("FAIL hold_done: got done_cnt %0d count %0d expected 1 576", done_cnt, wc_at_done);
    end
  endtask

  task automatic test_timeout();
    int c500, err_cyc;
    clear_log(); win_mode = 2; win_limit = 500; img_base = 10'd3;
    c500 = -1; err_cyc = -1;
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2500 && done_cnt == 0; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (c500 < 0 && wc_s == 10'd500) c500 = cyc - 1;
      if (err_cyc < 0 && err_s) err_cyc = cyc - 1;
    end
    checks++;
    if (err_cyc - c500 !== 64 || c500 < 0) begin
      errors++; $display("FAIL timeout_delay: got %0d cycles expected 64", err_cyc - c500);
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== err_cyc || err_at_done !== 1'b1) begin
      errors++; $display("FAIL timeout_done: got done_cnt %0d at %0d err %b expected 1 at %0d err 1", done_cnt, done_cyc, err_at_done, err_cyc);
    end
    checks++;
    if (wc_at_done !== 10'd500) begin errors++; $display("FAIL timeout_count: got %0d expected 500", wc_at_done); end
    cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (err_s !== 1'b1 || done_s !== 1'b0) begin
      errors++; $display("FAIL timeout_sticky: got err %b done %b expected 1 0", err_s, done_s);
    end
  endtask

  task automatic test_abort();
    int pix_before, reads_before;
    clear_log(); win_mode = 0; win_limit = 0; img_base = 10'd7;
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (busy_s !== 1'b0 || rd_en_s !== 1'b0 || err_s !== 1'b1) begin
      errors++; $display("FAIL abort_start_ignored: got busy %b rd %b err %b expected 0 0 1", busy_s, rd_en_s, err_s);
    end
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (busy_s !== 1'b1 || err_s !== 1'b0 || addr_s !== 10'd7) begin
      errors++; $display("FAIL abort_restart: got busy %b err %b addr %0d expected 1 0 7", busy_s, err_s, addr_s);
    end
    for (int i = 0; i < 600 && n_reads < 300; i++) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    pix_before = n_pix;
    cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (busy_s !== 1'b0 || rd_en_s !== 1'b0 || pv_s !== 1'b0) begin
      errors++; $display("FAIL abort_next: got busy %b rd %b pv %b expected 0 0 0", busy_s, rd_en_s, pv_s);
    end
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (done_cnt !== 0 || n_pix !== pix_before) begin
      errors++; $display("FAIL abort_quiet: got done_cnt %0d extra beats %0d expected 0 0", done_cnt, n_pix - pix_before);
    end
    img_base = 10'd40; reads_before = n_reads;
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (rd_en_s !== 1'b1 || addr_log[reads_before] !== 10'd40) begin
      errors++; $display("FAIL abort_new_base: got rd %b addr %0d expected 1 40", rd_en_s, addr_log[reads_before]);
    end
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_edges();
    clear_log(); win_mode = 0; win_limit = 0; img_base = 10'd1020;
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 50 && n_reads < 10; i++) cycle(1'b0, 1'b0, 1'b0);
    img_base = 10'd500;
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 50 && n_reads < 20; i++) cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if ({addr_log[3], addr_log[4]} !== {10'd1023, 10'd0}) begin
      errors++; $display("FAIL edge_wrap: got %0d then %0d expected 1023 then 0", addr_log[3], addr_log[4]);
    end
    checks++;
    if (addr_log[15] !== 10'd11) begin
      errors++; $display("FAIL edge_start_busy: got addr %0d expected 11", addr_log[15]);
    end
    checks++;
    if (rd_en_s !== 1'b1 || pv_s !== 1'b1) begin
      errors++; $display("FAIL edge_pre_reset: got rd %b pv %b expected 1 1", rd_en_s, pv_s);
    end
    #2; rst_n = 1'b0; #1;
    sample();
    checks++;
    if ({rd_en_s, addr_s, pv_s, pix_s, busy_s, done_s, err_s, wc_s, wr_s, wcl_s} !== 43'd0) begin
      errors++; $display("FAIL edge_async_reset: got %h expected 0",
                         {rd_en_s, addr_s, pv_s, pix_s, busy_s, done_s, err_s, wc_s, wr_s, wcl_s});
    end
    @(negedge clk); rst_n = 1'b1; prev_rd = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_window_track();
    test_hold();
    test_timeout();
    test_abort();
    test_edges();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
